// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one hex decoder.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan_ctrl #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000,
    parameter int GAP_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            data,
    output logic                  blank,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDXW    = $clog2(DIGITS);

    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(CLK_DIV - 1);
    localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP_CYC - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_START,
        ST_SCAN,
        ST_GAP
    } state_t;

    state_t                state_reg, state_next;
    logic [IDXW-1:0]       idx_reg, idx_next;
    logic [CNTW-1:0]       cnt_reg, cnt_next;
    logic [4*DIGITS-1:0]   shown_reg;
    logic [4*DIGITS-1:0]   shadow_reg;
    logic                  pending_reg;
    logic                  commit;
    logic                  dark;

    logic [3:0] nib [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = shown_reg[4*gi +: 4];
        end
    endgenerate

`ifdef DISP_LZB_EN
    // A digit goes dark when it and every more-significant nibble are zero; digit 0 never does.
    logic [DIGITS-1:0] lz_dark;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
            if (gi == 0) begin : g_first
                assign lz_dark[gi] = 1'b0;
            end else begin : g_upper
                assign lz_dark[gi] = ~|shown_reg[4*DIGITS-1:4*gi];
            end
        end
    endgenerate
    assign dark = lz_dark[idx_reg];
`else
    assign dark = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        frame_done = 1'b0;
        digit_en   = '1;
        blank      = 1'b1;
        data       = 4'h0;
        case (state_reg)
            ST_START: begin
                commit     = 1'b1;
                idx_next   = '0;
                cnt_next   = '0;
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (!dark) begin
                    digit_en = ~(DIGITS'(1) << idx_reg);
                    blank    = 1'b0;
                    data     = nib[idx_reg];
                end
                if (cnt_reg == SCAN_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_SCAN;
                    if (idx_reg == IDX_LAST) begin
                        frame_done = 1'b1;
                        commit     = 1'b1;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_START;
        endcase
    end

    // A load coinciding with a commit lands in the shadow after the old shadow is committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_START;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            shown_reg   <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            if (commit && pending_reg) begin
                shown_reg <= shadow_reg;
            end
            if (load) begin
                shadow_reg  <= value;
                pending_reg <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl (DIGITS=4, CLK_DIV=4, GAP_CYC=1).
module tb_display_scan_ctrl;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 1;
    localparam int FRAME   = DIGITS * (CLK_DIV + GAP_CYC);

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  data;
    logic        blank;
    logic [3:0]  digit_en;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DIGITS (DIGITS),
        .CLK_DIV(CLK_DIV),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .data      (data),
        .blank     (blank),
        .digit_en  (digit_en),
        .pending   (pending),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit lit(input logic [15:0] v, input int k);
`ifdef DISP_LZB_EN
        if (k == 0) return 1'b1;
        return (v >> (4 * k)) != 16'h0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] en_of(input int k);
        logic [3:0] e;
        e    = 4'b1111;
        e[k] = 1'b0;
        return e;
    endfunction

    // Walks one full frame starting from the cycle before its first SCAN slot.
    task automatic check_frame(input logic [15:0] v, input logic exp_pend);
        for (int d = 0; d < DIGITS; d++) begin
            for (int c = 0; c < CLK_DIV + GAP_CYC; c++) begin
                @(negedge clk);
                load = 1'b0;
                if (d == 0 && c == 0) check("frame_pending", pending, exp_pend);
                if (c < CLK_DIV) begin
                    check("scan_fd", frame_done, 1'b0);
                    if (lit(v, d)) begin
                        check("scan_en", digit_en, en_of(d));
                        check("scan_blank", blank, 1'b0);
                        check("scan_data", data, v[4*d +: 4]);
                    end else begin
                        check("lzb_en", digit_en, 4'b1111);
                        check("lzb_blank", blank, 1'b1);
                    end
                end else begin
                    check("gap_en", digit_en, 4'b1111);
                    check("gap_blank", blank, 1'b1);
                    check("gap_data", data, 4'h0);
                    check("gap_fd", frame_done, (d == DIGITS - 1) ? 1'b1 : 1'b0);
                end
            end
        end
        $display("frame value=%h pending=%0b checked", v, exp_pend);
    endtask

    task automatic wait_frame_done();
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_done) found = 1'b1;
        end
        check("frame_done_timeout", found, 1'b1);
    endtask

    // From a frame boundary, loads v while digit 1 is being scanned and ends on the next boundary.
    task automatic load_mid(input logic [15:0] v, input logic [15:0] old);
        repeat (7) @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
        check("load_pending", pending, 1'b1);
        if (lit(old, 1)) check("load_old_data", data, old[7:4]);
        $display("load value=%h mid-frame", v);
        wait_frame_done();
    endtask

    initial begin
        int n;
        bit found;
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_en", digit_en, 4'b1111);
        check("rst_blank", blank, 1'b1);
        check("rst_data", data, 4'h0);
        check("rst_pending", pending, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        rst = 1'b0;
        #1;
        check("start_en", digit_en, 4'b1111);
        check("start_blank", blank, 1'b1);
        $display("reset released");
        check_frame(16'h0000, 1'b0);

        load_mid(16'hA5C3, 16'h0000);
        check_frame(16'hA5C3, 1'b0);

        for (int r = 0; r < 2; r++) begin
            n     = 0;
            found = 1'b0;
            for (int i = 0; i < 2 * FRAME && !found; i++) begin
                @(negedge clk);
                n++;
                if (n == 1) check("fd_width", frame_done, 1'b0);
                if (frame_done) found = 1'b1;
            end
            check("fd_period", n, FRAME);
            $display("frame_done period=%0d", n);
        end

        repeat (7) @(negedge clk);
        check("pre_rst_en", digit_en, 4'b1101);
        check("pre_rst_data", data, 4'hC);
        rst = 1'b1;
        #1;
        check("midrst_en", digit_en, 4'b1111);
        check("midrst_blank", blank, 1'b1);
        check("midrst_data", data, 4'h0);
        check("midrst_pending", pending, 1'b0);
        check("midrst_fd", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_blank", blank, 1'b1);
        check("restart_en", digit_en, 4'b1111);
        $display("mid-scan reset released");
        check_frame(16'h0000, 1'b0);

        load_mid(16'h1234, 16'h0000);
        load  = 1'b1;
        value = 16'h5678;
        $display("load value=5678 on commit cycle");
        check_frame(16'h1234, 1'b1);
        check_frame(16'h5678, 1'b0);

        repeat (3) @(negedge clk);
        load  = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        value = 16'h3333;
        @(negedge clk);
        load = 1'b0;
        check("b2b_pending", pending, 1'b1);
        $display("load values 1111 2222 3333 back-to-back");
        wait_frame_done();
        check_frame(16'h3333, 1'b0);

        load_mid(16'h0040, 16'h3333);
        check_frame(16'h0040, 1'b0);
        load_mid(16'h0000, 16'h0040);
        check_frame(16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits sharing one hex decoder (`display_hexadecimal`). It holds a `4*DIGITS`-bit display value and steps through the digits one at a time. For each digit it presents one nibble to the shared decoder and drives the matching active-low digit enable, with a blanking gap between digits to suppress ghosting. New values are accepted at any time but only take effect on a frame boundary, so a frame never mixes old and new nibbles. It sits between the ALU result register and the board display pins.

## Interface
- `DIGITS`, 4, number of multiplexed digits (≥2).
- `CLK_DIV`, 50000, clock cycles each digit is lit per frame (≥1).
- `GAP_CYC`, 2, cycles with all digits off between consecutive digits (≥1).

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load`  in  1  single-cycle strobe that captures `value` into the shadow register.
- `value`  in  4*DIGITS  display value; nibble k feeds digit k, with digit 0 the rightmost.
- `data`  out  4  nibble for the shared hex decoder.
- `blank`  out  1  1 = decoder output forced all-off (segments 7'b111_1111).
- `digit_en`  out  DIGITS  active-low one-hot digit enable; all ones = all digits off.
- `pending`  out  1  a loaded value is waiting for the next frame boundary.
- `frame_done`  out  1  one-cycle pulse on the cycle that closes a frame.

## Operation
- Registers:
  - `shown`: the value currently displayed.
  - `shadow`: the last loaded value.
  - `pending`: shadow holds a value not yet committed.
  - `idx`: current digit index.
  - `cnt`: phase counter.
  - `state`.
- All outputs are decoded combinationally from these registers only; none depend on `load` or `value`.
- States:
  - START: one cycle. Commits the shadow to `shown` if `pending`, then clears `pending`. Sets `idx` to 0 and `cnt` to 0, then goes to SCAN.
  - SCAN: `digit_en` = ~(1<<idx), `data` = `shown[4*idx+:4]`, `blank` = 0. When `cnt` reaches CLK_DIV-1, clears `cnt` and goes to GAP.
  - GAP: `digit_en` all ones, `blank` = 1, `data` = 0. When `cnt` reaches GAP_CYC-1, clears `cnt` and then:
    - if `idx` = DIGITS-1: pulses `frame_done`, commits as in START, sets `idx` to 0, returns to SCAN;
    - otherwise increments `idx` and returns to SCAN.
- Load handling:
  - `load` = 1 copies `value` into `shadow` and sets `pending`.
  - A load while `pending` is already 1 overwrites the shadow; only the last load before a commit is shown.
  - A load on the same cycle as a commit: the commit uses the old shadow, the new value is written to the shadow, and `pending` stays 1.
- Reset: `rst` is asynchronous and may assert mid-operation. It forces:
  - `state` to START, `idx` = 0, `cnt` = 0;
  - `shown`, `shadow` and `pending` to 0.
- Output values while `rst` is high and during START: `digit_en` all ones, `blank` = 1, `data` = 0, `pending` = 0, `frame_done` = 0.

## Timing
- Frame length is exactly DIGITS*(CLK_DIV+GAP_CYC) cycles. `frame_done` therefore pulses at that fixed period.
- The first SCAN of digit 0 begins one cycle after `rst` deasserts (the START cycle).
- Load-to-display latency: from 1 cycle up to one full frame. `pending` rises the cycle after `load` and falls the cycle after the commit.
- `cnt` width is clog2(max(CLK_DIV,GAP_CYC)); `idx` width is clog2(DIGITS). `idx` wraps DIGITS-1 → 0 only at the frame boundary.

## Configuration
- `DISP_LZB_EN` defined: leading-zero blanking.
  - During SCAN of digit k, if every nibble of `shown` at position ≥k is zero and k>0, then `blank` = 1 and `digit_en` is all ones. Slot timing is unchanged.
  - Digit 0 is always shown.
- `DISP_LZB_EN` undefined: every digit is shown during its SCAN slot, including leading zeros.

## Test plan
Bench parameters: DIGITS=4, CLK_DIV=4, GAP_CYC=1.

1. Reset mid-SCAN → in the same cycle `digit_en`=4'b1111, `blank`=1, `data`=0. After release: 1 START cycle, then `digit_en`=4'b1110 for 4 cycles.
2. `load` of 16'hA5C3 mid-frame → `pending`=1, display unchanged until `frame_done`. Next frame `data` sequence is 3,C,5,A with `digit_en` 1110, 1101, 1011, 0111, each lit 4 cycles with 1 gap cycle between.
3. Free run → `frame_done` pulses exactly every 20 cycles, each pulse 1 cycle wide.
4. `load` 16'h1234, then `load` 16'h5678 on the commit cycle → next frame shows 1234 and `pending` stays 1; the following frame shows 5678 and `pending` falls.
5. With `DISP_LZB_EN`, `load` 16'h0040 → digits 3 and 2 are dark; digit 1 shows 4; digit 0 shows 0. Without the macro, all four digits are lit showing 0,0,4,0. With `DISP_LZB_EN`, 16'h0000 lights digit 0 only, showing 0.
6. Three back-to-back loads 16'h1111, 16'h2222, 16'h3333 within one frame → only 3333 is displayed after the next boundary.
